// File: rtl/risc_pkg.sv
// Shared definitions for the back end of the pipeline.
// Holds the MEM/WB bundle layout, write-back control encodings and helpers.
// Contents: bundle width, field LSB positions, bundle struct, wb enum, wb_writes_reg().
package risc_pkg;

   localparam int WB_BUNDLE_W = 42;

   // LSB positions of each field within the 42-bit bundle
   localparam int WB_MEMDATA = 26;   // [41:26]
   localparam int WB_ALU     = 10;   // [25:10]
   localparam int WB_RD      = 7;    // [9:7]
   localparam int WB_RS      = 4;    // [6:4]
   localparam int WB_STK     = 2;    // [3:2]
   localparam int WB_CTL     = 0;    // [1:0]

   typedef enum logic [1:0] {
      WB_NONE    = 2'b00,
      WB_ALU_REG = 2'b01,
      WB_MEM_REG = 2'b10,
      WB_OUT     = 2'b11
   } wb_ctl_e;

   // Field order (MSB first) mirrors the LSB positions above
   typedef struct packed {
      logic [15:0] mem_data;
      logic [15:0] alu;
      logic [2:0]  rd;
      logic [2:0]  rs;
      logic [1:0]  stk;
      logic [1:0]  ctl;
   } wb_bundle_t;

   function automatic logic wb_writes_reg(input logic [1:0] ctl);
      return (ctl == WB_ALU_REG) || (ctl == WB_MEM_REG);
   endfunction

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: stores the bundle plus valid and a committed (done) flag.
// Latency: one cycle, input captured on each posedge unless stalled or flushed.
// Backpressure: stall holds data/valid and marks a valid entry done so it commits once.
// Ports: clk, rst (sync, active-high), stall, flush, load_data/load_valid in; data/valid/done out.
module mem_wb_register
   import risc_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [WB_BUNDLE_W-1:0] load_data,
   input  logic                   load_valid,
   output logic [WB_BUNDLE_W-1:0] data,
   output logic                   valid,
   output logic                   done
);

   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
         done  <= 1'b0;
      end else if (flush) begin
         // flush beats stall: a held entry is dropped even if it never committed
         data  <= '0;
         valid <= 1'b0;
         done  <= 1'b0;
      end else if (stall) begin
         // the entry committed in the cycle before this hold began
         done  <= done | valid;
      end else begin
         data  <= load_data;
         valid <= load_valid;
         done  <= 1'b0;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: selects ALU/memory result, drives regfile write, forwarding and OutPort.
// Latency: bundle captured at edge N, write outputs during N..N+1, OutPort/count update at N+1.
// Backpressure: Stall holds the entry (forwarding stays valid, single commit); Flush loads a bubble.
// Ports: clk, rst, WritebackInput[41:0], InValid, Stall, Flush in; RegWrite*, Fwd*, OutPort, RetiredCount out.
module writeback_stage
   import risc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WB_BUNDLE_W-1:0] WritebackInput,
   input  logic                   InValid,
   input  logic                   Stall,
   input  logic                   Flush,
   output logic                   RegWrite,
   output logic [2:0]             RegWriteAddr,
   output logic [15:0]            RegWriteData,
   output logic                   FwdValid,
   output logic [2:0]             FwdAddr,
   output logic [15:0]            FwdData,
   output logic [15:0]            OutPort,
   output logic [CNT_W-1:0]       RetiredCount
);

   logic [WB_BUNDLE_W-1:0] data;
   logic                   valid;
   logic                   done;
   wb_bundle_t             ent;
   logic                   fire;
   logic                   writes_reg;
   logic                   unused_fields;

   mem_wb_register u_mem_wb (
      .clk        (clk),
      .rst        (rst),
      .stall      (Stall),
      .flush      (Flush),
      .load_data  (WritebackInput),
      .load_valid (InValid),
      .data       (data),
      .valid      (valid),
      .done       (done)
   );

   assign ent        = wb_bundle_t'(data);
   assign fire       = valid & ~done;
   assign writes_reg = wb_writes_reg(ent.ctl);

   // source and stack fields ride along but are not consumed here
   assign unused_fields = ^{ent.rs, ent.stk};

   assign RegWrite     = fire & writes_reg;
   assign RegWriteAddr = ent.rd;
   assign RegWriteData = (ent.ctl == WB_MEM_REG) ? ent.mem_data : ent.alu;

   // forwarding tracks the held entry, not the commit pulse
   assign FwdValid = valid & writes_reg;
   assign FwdAddr  = RegWriteAddr;
   assign FwdData  = RegWriteData;

   always_ff @(posedge clk) begin
      if (rst) begin
         OutPort      <= '0;
         RetiredCount <= '0;
      end else begin
         if (fire && (ent.ctl == WB_OUT))
            OutPort <= ent.alu;
         if (fire && (RetiredCount != {CNT_W{1'b1}}))
            RetiredCount <= RetiredCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: two instances (16-bit and 2-bit counter) share stimulus.
// Inputs driven 1 time unit after posedge; outputs checked at that point (registered state only).
// Expected values are hand-computed constants per vector.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [41:0] wbin;
   logic        inv, stall, flush;

   logic        rw,  rw2;
   logic [2:0]  rwa, rwa2, fa, fa2;
   logic [15:0] rwd, rwd2, fd, fd2, op, op2;
   logic        fv,  fv2;
   logic [15:0] cnt;
   logic [1:0]  cnt2;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   writeback_stage #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .WritebackInput(wbin), .InValid(inv), .Stall(stall), .Flush(flush),
      .RegWrite(rw), .RegWriteAddr(rwa), .RegWriteData(rwd),
      .FwdValid(fv), .FwdAddr(fa), .FwdData(fd), .OutPort(op), .RetiredCount(cnt)
   );

   writeback_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .WritebackInput(wbin), .InValid(inv), .Stall(stall), .Flush(flush),
      .RegWrite(rw2), .RegWriteAddr(rwa2), .RegWriteData(rwd2),
      .FwdValid(fv2), .FwdAddr(fa2), .FwdData(fd2), .OutPort(op2), .RetiredCount(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   function automatic logic [41:0] bundle(input logic [15:0] mem, input logic [15:0] alu,
                                          input logic [2:0] rd, input logic [1:0] wb);
      return {mem, alu, rd, 3'b000, 2'b00, wb};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [41:0] b, input logic v);
      wbin = b;
      inv  = v;
   endtask

   int pulses, fwd_cycles;

   initial begin
      rst = 1'b1; wbin = '0; inv = 1'b0; stall = 1'b0; flush = 1'b0;
      step(); step();
      rst = 1'b0;

      // reset state
      check("rst_regwrite", rw, 0);
      check("rst_fwdvalid", fv, 0);
      check("rst_wdata",    rwd, 0);
      check("rst_outport",  op, 0);
      check("rst_count",    cnt, 0);
      check("rst_count2",   cnt2, 0);

      // 1: ALU write
      drive(bundle(16'h0000, 16'h1234, 3'd5, 2'b01), 1'b1); step();
      check("t1_regwrite", rw, 1);
      check("t1_addr",     rwa, 5);
      check("t1_data",     rwd, 16'h1234);
      check("t1_fwdaddr",  fa, 5);
      drive('0, 1'b0); step();
      check("t1_count",    cnt, 1);
      check("t1_bubble_rw", rw, 0);

      // 2: memory-data write
      drive(bundle(16'hBEEF, 16'h0040, 3'd2, 2'b10), 1'b1); step();
      check("t2_regwrite", rw, 1);
      check("t2_data",     rwd, 16'hBEEF);
      check("t2_fwddata",  fd, 16'hBEEF);
      check("t2_fwdvalid", fv, 1);
      drive('0, 1'b0); step();
      check("t2_count",    cnt, 2);

      // 3: OutPort write
      drive(bundle(16'h0000, 16'h00A5, 3'd3, 2'b11), 1'b1); step();
      check("t3_regwrite", rw, 0);
      check("t3_fwdvalid", fv, 0);
      check("t3_out_early", op, 0);
      drive('0, 1'b0); step();
      check("t3_outport",  op, 16'h00A5);
      check("t3_count",    cnt, 3);
      step();
      check("t3_out_hold", op, 16'h00A5);
      check("t3_count2",   cnt2, 3);

      // 4: stall for 3 cycles after capture
      pulses = 0; fwd_cycles = 0;
      drive(bundle(16'h0000, 16'h0777, 3'd6, 2'b01), 1'b1); step();
      pulses += int'(rw); fwd_cycles += int'(fv);
      stall = 1'b1;
      drive(bundle(16'h0000, 16'hDEAD, 3'd1, 2'b01), 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(rw); fwd_cycles += int'(fv);
         check("t4_held_data", rwd, 16'h0777);
      end
      stall = 1'b0;
      drive('0, 1'b0); step();
      check("t4_pulses",   pulses, 1);
      check("t4_fwd_cyc",  fwd_cycles, 4);
      check("t4_count",    cnt, 4);
      check("t4_count2",   cnt2, 3);
      check("t4_fwd_off",  fv, 0);

      // 5: flush together with stall and a valid input
      flush = 1'b1; stall = 1'b1;
      drive(bundle(16'h0000, 16'h0222, 3'd4, 2'b01), 1'b1); step();
      check("t5_regwrite", rw, 0);
      check("t5_fwdvalid", fv, 0);
      flush = 1'b0; stall = 1'b0;
      drive('0, 1'b0); step();
      check("t5_count",    cnt, 4);

      // 6: saturating 2-bit counter, then reset mid-stream
      rst = 1'b1; step(); rst = 1'b0;
      check("t6_rst_count", cnt, 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) drive(bundle(16'h0000, 16'h5A5A, 3'd0, 2'b11), 1'b1);
         else        drive(bundle(16'h0000, 16'(i + 1), 3'd1, 2'b01), 1'b1);
         step();
         check("t6_cnt16", cnt, 32'(i));
         check("t6_cnt2",  cnt2, (i > 3) ? 3 : i);
      end
      drive('0, 1'b0); step();
      check("t6_cnt16_end", cnt, 5);
      check("t6_cnt2_end",  cnt2, 3);
      check("t6_outport",   op2, 16'h5A5A);
      drive(bundle(16'h0000, 16'h0999, 3'd7, 2'b01), 1'b1); step();
      check("t6_pre_rw", rw2, 1);
      rst = 1'b1; stall = 1'b1; step();
      check("t6_rst_rw",   rw2, 0);
      check("t6_rst_fv",   fv2, 0);
      check("t6_rst_op",   op2, 0);
      check("t6_rst_cnt2", cnt2, 0);
      check("t6_rst_cnt",  cnt, 0);
      rst = 1'b0; stall = 1'b0; drive('0, 1'b0); step();
      check("t6_no_commit", cnt2, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
